// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision constants, the dot-product FSM
// state type, and the combinational FP_Multiplier / FP_Adder functions.
// The functions flush subnormal inputs and outputs to signed zero, round
// to nearest-even, saturate overflow to infinity and return a quiet NaN
// for invalid operations.
package fp_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FP_W-1:0]  FP_ZERO      = 32'h0000_0000;
    localparam logic [FP_W-1:0]  FP_QNAN      = 32'h7FC0_0000;
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fp_dot_state_t;

    // Round a normalised 24-bit significand (hidden bit at m[23]) and pack.
    function automatic logic [FP_W-1:0] fp_pack(input logic s, input int e,
                                                 input logic [23:0] m,
                                                 input logic g, input logic st);
        logic [24:0] mr;
        int          eo;
        eo = e;
        mr = {1'b0, m} + {24'h0, g & (st | m[0])};
        if (mr[24]) begin
            mr = mr >> 1;
            eo = e + 1;
        end
        if (eo >= 255) return {s, EXP_ALL_ONES, 23'h0};
        if (eo <= 0)   return {s, 31'h0};
        return {s, eo[7:0], mr[22:0]};
    endfunction

    // FP_Multiplier
    function automatic logic [FP_W-1:0] fp_mul(input logic [FP_W-1:0] x,
                                               input logic [FP_W-1:0] y);
        logic        s;
        logic [7:0]  ex, ey;
        logic [47:0] p;
        int          e;
        s  = x[31] ^ y[31];
        ex = x[30:23];
        ey = y[30:23];
        if ((ex == EXP_ALL_ONES && |x[22:0]) || (ey == EXP_ALL_ONES && |y[22:0]))
            return FP_QNAN;
        if (ex == EXP_ALL_ONES || ey == EXP_ALL_ONES)
            return (ex == 8'h0 || ey == 8'h0) ? FP_QNAN : {s, EXP_ALL_ONES, 23'h0};
        if (ex == 8'h0 || ey == 8'h0)
            return {s, 31'h0};
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e = int'(ex) + int'(ey) - 127;
        if (p[47])
            return fp_pack(s, e + 1, p[47:24], p[23], |p[22:0]);
        return fp_pack(s, e, p[46:23], p[22], |p[21:0]);
    endfunction

    // FP_Adder
    function automatic logic [FP_W-1:0] fp_add(input logic [FP_W-1:0] x,
                                               input logic [FP_W-1:0] y);
        logic [7:0]  ex, ey, d;
        logic [31:0] big, sml;
        logic [27:0] mb, ms;
        int          e;
        ex = x[30:23];
        ey = y[30:23];
        if ((ex == EXP_ALL_ONES && |x[22:0]) || (ey == EXP_ALL_ONES && |y[22:0]))
            return FP_QNAN;
        if (ex == EXP_ALL_ONES && ey == EXP_ALL_ONES)
            return (x[31] != y[31]) ? FP_QNAN : x;
        if (ex == EXP_ALL_ONES) return x;
        if (ey == EXP_ALL_ONES) return y;
        if (ex == 8'h0 && ey == 8'h0) return {x[31] & y[31], 31'h0};
        if (ex == 8'h0) return y;
        if (ey == 8'h0) return x;
        if (y[30:0] > x[30:0]) begin
            big = y;
            sml = x;
        end else begin
            big = x;
            sml = y;
        end
        d  = big[30:23] - sml[30:23];
        // 1 carry bit, hidden bit, 23 fraction bits, guard/round/sticky
        mb = {2'b01, big[22:0], 3'b000};
        ms = {2'b01, sml[22:0], 3'b000};
        for (int i = 0; i < 27; i++)
            if (i < int'(d)) ms = {1'b0, ms[27:2], ms[1] | ms[0]};
        e = int'(big[30:23]);
        if (x[31] == y[31]) begin
            mb = mb + ms;
            if (mb[27]) begin
                mb = {1'b0, mb[27:2], mb[1] | mb[0]};
                e  = e + 1;
            end
        end else begin
            mb = mb - ms;
            if (mb == 28'h0) return FP_ZERO;
            for (int i = 0; i < 26; i++) begin
                if (!mb[26]) begin
                    mb = mb << 1;
                    e  = e - 1;
                end
            end
        end
        return fp_pack(big[31], e, mb[26:3], mb[2], |mb[1:0]);
    endfunction

endpackage

// File: rtl/fp_dot_product_unit_mac_stage.sv
// fp_mac_stage: two-stage multiply-accumulate datapath.
//   stage 1: prod_reg <= fp_mul(a, b) when load; prod_vld follows load.
//   stage 2: acc <= fp_add(acc, prod_reg) whenever prod_vld.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clr           synchronous clear of acc/prod_reg/prod_vld (new product)
//   load          operand pair a/b accepted this cycle
//   a, b          IEEE-754 single operands
//   acc           running sum
//   prod_vld      prod_reg holds a product not yet accumulated
//   ovf           (only with FP_DOT_OVF_FLAG_EN) sticky: a product or sum
//                 had an all-ones exponent since the last clr
module fp_mac_stage
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] acc,
    output logic            prod_vld
`ifdef FP_DOT_OVF_FLAG_EN
    ,
    output logic            ovf
`endif
);

    logic [FP_W-1:0] prod_reg;
    logic [FP_W-1:0] mul_res;
    logic [FP_W-1:0] add_res;

    assign mul_res = fp_mul(a, b);
    assign add_res = fp_add(acc, prod_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_reg <= FP_ZERO;
            prod_vld <= 1'b0;
            acc      <= FP_ZERO;
        end else if (clr) begin
            prod_reg <= FP_ZERO;
            prod_vld <= 1'b0;
            acc      <= FP_ZERO;
        end else begin
            prod_vld <= load;
            if (load)
                prod_reg <= mul_res;
            if (prod_vld)
                acc <= add_res;
        end
    end

`ifdef FP_DOT_OVF_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (clr)
            ovf <= 1'b0;
        else if ((load && mul_res[30:23] == EXP_ALL_ONES) ||
                 (prod_vld && add_res[30:23] == EXP_ALL_ONES))
            ovf <= 1'b1;
    end
`endif

endmodule

// File: rtl/fp_dot_product_unit.sv
// fp_dot_product_unit: streams VEC_LEN operand pairs, multiplies each pair
// and accumulates the products; the final single-precision sum is offered
// on a valid/ready output.
// Optional feature macro: FP_DOT_OVF_FLAG_EN adds the sticky ovf output.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                begin a new dot product (only honoured in IDLE)
//   in_valid/in_ready    operand handshake for a, b
//   a, b                 IEEE-754 single operands
//   out_valid/out_ready  result handshake
//   result               final sum (equals the accumulator)
//   busy                 accumulating or draining
//   ovf                  (FP_DOT_OVF_FLAG_EN only) exponent 8'hFF seen
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting operand pairs, one per cycle
// DRAIN | last product being added into the accumulator
// DONE  | result valid, waiting for out_ready
module fp_dot_product_unit
    import fp_pkg::*;
#(
    parameter int VEC_LEN = 8,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] result,
    output logic            busy
`ifdef FP_DOT_OVF_FLAG_EN
    ,
    output logic            ovf
`endif
);

    fp_dot_state_t   state;
    logic [CNT_W-1:0] count;
    logic            accept;
    logic            last;
    logic            clr;
    logic            prod_vld;
    logic [FP_W-1:0] acc;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign last     = accept && (count == CNT_W'(VEC_LEN - 1));
    assign clr      = (state == IDLE) && start;
    assign busy     = (state == ACCUM) || (state == DRAIN);
    // prod_vld is always clear by DONE; the term keeps the result from being
    // offered while a product is still in flight.
    assign out_valid = (state == DONE) && !prod_vld;
    assign result    = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        count <= '0;
                    end
                end
                ACCUM: begin
                    if (accept)
                        count <= count + CNT_W'(1);
                    if (last)
                        state <= DRAIN;
                end
                // The final product sits in prod_reg and lands in acc on
                // this edge, so DONE already sees the finished sum.
                DRAIN: state <= DONE;
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fp_mac_stage u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (accept),
        .a        (a),
        .b        (b),
        .acc      (acc),
        .prod_vld (prod_vld)
`ifdef FP_DOT_OVF_FLAG_EN
        ,
        .ovf      (ovf)
`endif
    );

endmodule

// File: tb/tb_fp_dot_product_unit.sv
// Bench for fp_dot_product_unit: instance 0 has VEC_LEN=2, instance 1 has
// VEC_LEN=1. Expected sums are pushed to a queue when a dot product is
// started and popped when the unit presents its result.
module tb_fp_dot_product_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] a         [2];
    logic [31:0] b         [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] result    [2];
    logic        busy      [2];
`ifdef FP_DOT_OVF_FLAG_EN
    logic        ovf       [2];
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fp_dot_product_unit #(.VEC_LEN(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .a(a[0]), .b(b[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0])
`ifdef FP_DOT_OVF_FLAG_EN
        , .ovf(ovf[0])
`endif
    );

    fp_dot_product_unit #(.VEC_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .a(a[1]), .b(b[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1])
`ifdef FP_DOT_OVF_FLAG_EN
        , .ovf(ovf[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input int d, input string tag);
        chk({tag, "_in_ready"},  32'(in_ready[d]),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid[d]), 32'd0);
        chk({tag, "_busy"},      32'(busy[d]),      32'd0);
        chk({tag, "_result"},    result[d],         32'h0);
    endtask

    task automatic do_start(input int d);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input int d, input logic [31:0] av, input logic [31:0] bv);
        int guard;
        guard       = 0;
        a[d]        = av;
        b[d]        = bv;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("send_ready_wait", 32'(guard < 20), 32'd1);
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    // Right after the final send: out_valid low in t+1, high in t+2.
    task automatic chk_latency(input int d, input string tag);
        chk({tag, "_lat_t1"}, 32'(out_valid[d]), 32'd0);
        @(negedge clk);
        chk({tag, "_lat_t2"}, 32'(out_valid[d]), 32'd1);
    endtask

    task automatic collect(input int d, input int hold, input logic with_start, input string tag);
        int          guard;
        logic [31:0] expv;
        guard = 0;
        while (!out_valid[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_out_valid"}, 32'(out_valid[d]), 32'd1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk({tag, "_result"}, result[d], expv);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"},  32'(out_valid[d]), 32'd1);
            chk({tag, "_hold_result"}, result[d], expv);
        end
        out_ready[d] = 1'b1;
        start[d]     = with_start;
        @(negedge clk);
        out_ready[d] = 1'b0;
        start[d]     = 1'b0;
        chk({tag, "_back_idle"}, {29'h0, out_valid[d], busy[d], in_ready[d]}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d]     = 1'b0;
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            a[d]         = 32'h0;
            b[d]         = 32'h0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs(0, "reset0");
        chk_reset_outputs(1, "reset1");
        rst = 1'b0;
        @(negedge clk);

        // Basic sum 1*3 + 2*4 = 11, back-to-back
        do_start(0);
        chk("basic_busy", 32'(busy[0]), 32'd1);
        exp_q.push_back(32'h4130_0000);
        send(0, 32'h3F80_0000, 32'h4040_0000);
        send(0, 32'h4000_0000, 32'h4080_0000);
        chk_latency(0, "basic");
        collect(0, 0, 1'b0, "basic");

        // Single pair 34*96 = 3264 on VEC_LEN=1
        do_start(1);
        exp_q.push_back(32'h454C_0000);
        send(1, 32'h4208_0000, 32'h42C0_0000);
        chk_latency(1, "single");
        collect(1, 0, 1'b0, "single");

        // Exact cancellation, with out_ready held low for 5 cycles
        do_start(0);
        exp_q.push_back(32'h0000_0000);
        send(0, 32'h4000_0000, 32'h4040_0000);
        send(0, 32'h4000_0000, 32'hC040_0000);
        collect(0, 5, 1'b0, "cancel");

        // Different-exponent subtraction 2*4 + 1*(-3) = 5
        do_start(0);
        exp_q.push_back(32'h40A0_0000);
        send(0, 32'h4000_0000, 32'h4080_0000);
        send(0, 32'h3F80_0000, 32'hC040_0000);
        collect(0, 0, 1'b0, "sub");

        // in_valid while idle must not be consumed
        a[0] = 32'h7F00_0000;
        b[0] = 32'h4000_0000;
        in_valid[0] = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        in_valid[0] = 1'b0;

        // Gapped input plus a start pulse in ACCUM: same 11.0 as gap-free
        do_start(0);
        exp_q.push_back(32'h4130_0000);
        send(0, 32'h3F80_0000, 32'h4040_0000);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("gap_still_accum", 32'(in_ready[0]), 32'd1);
        send(0, 32'h4000_0000, 32'h4080_0000);
        chk_latency(0, "gap");
        collect(0, 0, 1'b0, "gap");

        // Reset after 1 of 2 pairs: outputs drop immediately
        do_start(0);
        send(0, 32'h3F80_0000, 32'h4040_0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs(0, "abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_start(0);
        exp_q.push_back(32'h4130_0000);
        send(0, 32'h3F80_0000, 32'h4040_0000);
        send(0, 32'h4000_0000, 32'h4080_0000);
        collect(0, 0, 1'b0, "after_abort");

        // start together with out_ready in DONE returns to IDLE only
        do_start(1);
        exp_q.push_back(32'h4180_0000);
        send(1, 32'h4080_0000, 32'h4080_0000);
        collect(1, 0, 1'b1, "done_start");
        @(negedge clk);
        chk("done_start_idle", 32'(busy[1]), 32'd0);

`ifdef FP_DOT_OVF_FLAG_EN
        do_start(1);
        chk("ovf_clear0", 32'(ovf[1]), 32'd0);
        exp_q.push_back(32'h7F80_0000);
        send(1, 32'h7F00_0000, 32'h4000_0000);
        @(negedge clk);
        chk("ovf_set_valid", 32'(out_valid[1]), 32'd1);
        chk("ovf_set", 32'(ovf[1]), 32'd1);
        collect(1, 0, 1'b0, "ovf");
        do_start(1);
        chk("ovf_cleared", 32'(ovf[1]), 32'd0);
        exp_q.push_back(32'h3F80_0000);
        send(1, 32'h3F80_0000, 32'h3F80_0000);
        collect(1, 0, 1'b0, "ovf_after");
        chk("ovf_stays_clear", 32'(ovf[1]), 32'd0);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
